spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Mode-0 (CPOL=0, CPHA=0), MSB-first, single-byte SPI master.
- Drives the ss/sck/mosi lines consumed by the board's spi_slave and captures miso.
- Used as the upstream stimulus stage on a second board or in the same FPGA for loopback bring-up.
- Accepts a byte on a start strobe, shifts it out while shifting a reply in, then presents the reply with a one-cycle done pulse.

Parameters:
- WIDTH, 8: bits per transfer.
- CLK_DIV, 4: clk cycles per sck half-period. Legal minimum is 2. Use ≥4 when driving spi_slave, which oversamples sck with clk.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- start  input  1  request a transfer; sampled only in IDLE
- din  input  WIDTH  byte to transmit; latched on the accepted start cycle
- dout  output  WIDTH  last received byte; registered
- done  output  1  one-cycle pulse when dout is updated
- busy  output  1  high from accept until end of GAP
- ss  output  1  slave select, active-low
- sck  output  1  serial clock, idle low
- mosi  output  1  serial data out
- miso  input  1  serial data in

Behaviour:
- Reset (rst=0, async):
  - ss=1, sck=0, mosi=0, done=0, busy=0, dout=0.
  - State IDLE; counters cleared.
  - Effect is immediate, including mid-transfer; no done is produced for an aborted transfer.
- Half-period tick: a down-counter loads CLK_DIV-1 and pulses tick when it reaches 0. It runs only outside IDLE.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: on a cycle T with start=1:
  - shift register <= din.
  - At T+1: ss=0, busy=1, mosi=din[WIDTH-1], state SETUP.
- SETUP: one half-period with sck low. On tick, drive sck=1 and go to SHIFT.
- SHIFT: sck toggles on every tick.
  - On the clk edge that drives sck 0->1: shift miso into the receive register LSB.
  - On the clk edge that drives sck 1->0: put the next tx bit on mosi.
  - Exactly WIDTH rising edges.
  - After the WIDTH-th falling edge (sck=0), go to HOLD; mosi holds the last bit.
- HOLD: one half-period. On tick:
  - ss=1, dout <= receive register, done=1 for one cycle.
  - State GAP.
- GAP: one half-period with ss high and busy still 1. On tick, busy=0 and state IDLE.
- Timing for CLK_DIV=4, WIDTH=8, start accepted at cycle T:
  - ss falls at T+1.
  - First sck rise at T+1+CLK_DIV.
  - WIDTH-th sck fall at T+1+2·WIDTH·CLK_DIV.
  - ss rises and done fires at T+1+(2·WIDTH+1)·CLK_DIV = T+69.
  - busy falls at T+73.
- start while busy: ignored, with no queuing. din changes after accept have no effect.
- start held high continuously: a new transfer is accepted on the first IDLE cycle. ss-high time between frames is ≥ CLK_DIV cycles.
- dout holds its value between transfers; it changes only together with done.
- sck, ss and mosi are driven straight from flops, with no combinational paths to pins.

Decomposition:
- Shared package spi_pkg:
  - state encoding (IDLE, SETUP, SHIFT, HOLD, GAP) as localparams;
  - default WIDTH and CLK_DIV constants, shared with spi_slave benches.
- One natural sub-module: spi_tick_gen (parameter CLK_DIV; ports clk, rst, en, tick), the half-period counter.

Test Plan:
- Reset: hold rst=0 with start=1, miso=1 -> ss=1, sck=0, mosi=0, busy=0, done=0, dout=0x00 throughout.
- Single transfer (CLK_DIV=4), din=0xA5, bench slave returns 0x3C MSB-first ->
  - mosi sampled on sck rises = 1,0,1,0,0,1,0,1;
  - exactly 8 sck rises;
  - done pulse at T+69 with dout=0x3C;
  - busy low at T+73.
- start pulse with din=0xFF during a 0x12 transfer -> ignored; only one ss low frame; mosi pattern is 0x12.
- start held high, din=0x81 -> consecutive frames, each 8 rises; ss high ≥4 cycles between frames; done once per frame.
- Reset asserted after the 3rd sck rise -> ss=1, sck=0 without waiting for clk; no done; dout unchanged (0x00); a fresh transfer after release completes normally.
- Loopback to spi_slave, whose reply byte is the bitwise inverse of the byte it last received -> send 0x5A, then 0x00; second dout = 0xA5.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI constants: FSM state encoding and default frame geometry.
// The defaults are also used by the spi_slave benches.
package spi_pkg;

  localparam int SPI_WIDTH   = 8;
  localparam int SPI_CLK_DIV = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for the SPI master.
// Down-counter that reloads CLK_DIV-1 and flags tick on terminal count.
// Parked at the reload value while disabled, so the first tick after
// enable lands exactly CLK_DIV cycles later.
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count down while enabled; reload on terminal count or when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= LOAD;
    end else if (!en || cnt == '0) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0, MSB-first, single-frame SPI master.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; tick counter parked
// SETUP | ss low, first data bit on mosi, sck low for one half-period
// SHIFT | sck toggles per tick; sample miso on rise, next mosi on fall
// HOLD  | last fall done, sck low for one half-period before ss rises
// GAP   | ss high for one half-period, busy still asserted
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = SPI_WIDTH,
  parameter int CLK_DIV = SPI_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             done,
  output logic             busy,
  output logic             ss,
  output logic             sck,
  output logic             mosi,
  input  logic             miso
);

  localparam int BW = $clog2(WIDTH + 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [BW-1:0]    bits_left;
  logic             tick;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  // Frame sequencer; all pin-facing outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bits_left <= '0;
      dout      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      ss        <= 1'b1;
      sck       <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_sr     <= din;
            mosi      <= din[WIDTH-1];
            ss        <= 1'b0;
            busy      <= 1'b1;
            bits_left <= BW'(WIDTH);
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // The SETUP exit edge is also the first sck rise.
          if (tick) begin
            sck       <= 1'b1;
            rx_sr     <= {rx_sr[WIDTH-2:0], miso};
            bits_left <= bits_left - 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!sck) begin
              sck       <= 1'b1;
              rx_sr     <= {rx_sr[WIDTH-2:0], miso};
              bits_left <= bits_left - 1'b1;
            end else begin
              sck <= 1'b0;
              if (bits_left == '0) begin
                state <= ST_HOLD;
              end else begin
                tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                mosi  <= tx_sr[WIDTH-2];
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            ss    <= 1'b1;
            dout  <= rx_sr;
            done  <= 1'b1;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master with a behavioural SPI slave.
module tb_spi_master;
  import spi_pkg::*;

  localparam int W   = SPI_WIDTH;
  localparam int DIV = SPI_CLK_DIV;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         done, busy, ss, sck, mosi, miso;

  spi_master #(.WIDTH(W), .CLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .dout  (dout),
    .done  (done),
    .busy  (busy),
    .ss    (ss),
    .sck   (sck),
    .mosi  (mosi),
    .miso  (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Behavioural slave: presents the reply MSB-first, advancing one bit per
  // sck fall; captures mosi on sck rises. In loop mode its reply is the
  // inverse of the byte it received in the previous frame.
  bit           force_hi = 1'b1;
  bit           loop_mode = 1'b0;
  logic [W-1:0] slv_tx = '0;
  logic [W-1:0] frame_byte = '0;
  logic [W-1:0] slv_rx = '0;
  logic [W-1:0] last_rx = '0;
  int           slv_rises = 0;
  int           slv_falls = 0;
  int           last_rises = 0;
  int           frames = 0;
  logic         ss_q = 1'b1;
  logic         sck_q = 1'b0;

  always @(ss or sck) begin
    if (ss !== ss_q) begin
      if (ss === 1'b0) begin
        frames++;
        slv_rises = 0;
        slv_falls = 0;
        slv_rx = '0;
        frame_byte = loop_mode ? ~last_rx : slv_tx;
      end else if (ss === 1'b1 && ss_q === 1'b0) begin
        last_rx = slv_rx;
        last_rises = slv_rises;
      end
      ss_q = ss;
    end else if (ss === 1'b0 && sck !== sck_q) begin
      if (sck === 1'b1) begin
        slv_rx = {slv_rx[W-2:0], mosi};
        slv_rises++;
      end else begin
        slv_falls++;
      end
    end
    sck_q = sck;
  end

  assign miso = force_hi ? 1'b1 :
                (slv_falls < W) ? frame_byte[W-1-slv_falls] : 1'b0;

  // Done pulses and length of ss-high runs, sampled mid-cycle.
  int done_cnt = 0;
  int hi_run = 0;
  int last_gap = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ss) begin
      hi_run++;
    end else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One frame. Acceptance edge k => done seen at k+68, busy low at k+72
  // (T+69 / T+73 with T+1 = k, for DIV=4, W=8).
  task automatic do_xfer(input logic [W-1:0] d, input logic [W-1:0] reply,
                         input bit chk_dout, input int inject_at);
    int t_acc, f0, d0;
    bit got_done, got_idle;
    @(negedge clk);
    din = d;
    slv_tx = reply;
    start = 1'b1;
    f0 = frames;
    d0 = done_cnt;
    @(negedge clk);
    t_acc = cyc;
    start = 1'b0;
    din = W'($urandom);
    check("ss_low_after_accept", ss, 1'b0);
    check("busy_after_accept", busy, 1'b1);
    check("mosi_msb_after_accept", mosi, d[W-1]);
    got_done = 1'b0;
    got_idle = 1'b0;
    for (int n = 1; n < 300 && !got_idle; n++) begin
      start = (n == inject_at);
      if (n == inject_at) din = '1;
      @(negedge clk);
      start = 1'b0;
      if (done && !got_done) begin
        got_done = 1'b1;
        check("done_time", cyc - t_acc, 32'd68);
        if (chk_dout) check("dout_value", dout, reply);
      end
      if (!busy) begin
        got_idle = 1'b1;
        check("busy_fall_time", cyc - t_acc, 32'd72);
      end
    end
    check("done_seen", got_done, 1'b1);
    check("busy_fall_seen", got_idle, 1'b1);
    check("one_frame", frames - f0, 32'd1);
    check("one_done", done_cnt - d0, 32'd1);
    check("sck_rises", last_rises, W);
    check("mosi_byte", last_rx, d);
  endtask

  initial begin
    logic [W-1:0] rd, rr;
    int f0, d0;

    // Power-up reset with start and miso high.
    rst = 1'b0;
    start = 1'b1;
    force_hi = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_ss", ss, 1'b1);
      check("rst_sck", sck, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dout", dout, '0);
    end
    start = 1'b0;
    force_hi = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Reset after the 3rd sck rise: immediate abort, no done.
    @(negedge clk);
    din = 8'hC3;
    slv_tx = 8'h66;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = done_cnt;
    for (int n = 0; n < 100 && slv_rises < 3; n++) @(negedge clk);
    check("reached_rise3", slv_rises, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    check("abort_ss", ss, 1'b1);
    check("abort_sck", sck, 1'b0);
    check("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_dout", dout, '0);
    rst = 1'b1;

    // Fresh transfer after reset, then the reference frame.
    do_xfer(8'h96, 8'h41, 1'b1, 0);
    do_xfer(8'hA5, 8'h3C, 1'b1, 0);

    // start pulse mid-frame is ignored.
    f0 = frames;
    do_xfer(8'h12, 8'hE7, 1'b1, 20);
    repeat (10) @(negedge clk);
    check("no_queued_frame", frames - f0, 32'd1);
    check("dout_holds", dout, 8'hE7);

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      rd = W'($urandom);
      rr = W'($urandom);
      do_xfer(rd, rr, 1'b1, 0);
    end

    // start held high: back-to-back frames.
    @(negedge clk);
    slv_tx = 8'h5C;
    din = 8'h81;
    f0 = frames;
    d0 = done_cnt;
    start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int n = 0; n < 200 && ss; n++) @(negedge clk);
      check("held_ss_low", ss, 1'b0);
      @(negedge clk);
      if (f > 0) check("held_gap_ge_div", (last_gap >= DIV), 1'b1);
      for (int n = 0; n < 200 && !ss; n++) @(negedge clk);
      check("held_ss_high", ss, 1'b1);
      @(negedge clk);
      check("held_rises", last_rises, W);
      check("held_mosi", last_rx, 8'h81);
      check("held_dout", dout, 8'h5C);
    end
    start = 1'b0;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check("held_idle", busy, 1'b0);
    check("held_frames", frames - f0, 32'd3);
    check("held_done_per_frame", done_cnt - d0, 32'd3);

    // Loopback-style slave: reply is inverse of previously received byte.
    loop_mode = 1'b1;
    do_xfer(8'h5A, 8'h00, 1'b0, 0);
    do_xfer(8'h00, 8'hA5, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
